rs_station: RTL and testbench

- Reservation station: the receiving end of the common data bus (CDB) broadcast.
- Holds N issued instructions and snoops CDB (enable, tag, data) to capture pending operands.
- Dispatches ready entries to its functional unit.
- Frees an entry when the CDB broadcasts that entry's own tag, i.e. its result has been published.
- One instance per unit class (add, logic, mul, load, store), each with a disjoint tag range.

---
 rtl/tomasulo_pkg.sv | 18 +
 rtl/rs_station_if.sv | 40 ++++
 rtl/rs_entry.sv | 92 +++++++++
 rtl/rs_station.sv | 78 +++++++
 tb/tb_rs_station.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: bus widths, per-class tag ranges and entry states.
package tomasulo_pkg;

  localparam int TAG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int OP_W     = 4;
  localparam int TAG_NONE = 0;

  // Three station tags per unit class; ranges must stay disjoint.
  localparam int ADD_BASE_TAG   = 1;
  localparam int LOGIC_BASE_TAG = 4;
  localparam int MUL_BASE_TAG   = 7;
  localparam int LOAD_BASE_TAG  = 10;
  localparam int STORE_BASE_TAG = 13;

  typedef enum logic [1:0] {FREE, WAIT, READY, EXEC} entry_state_t;

endpackage

// File: rtl/rs_station_if.sv
// Issue, CDB and execute signals between a reservation station and its neighbours.
interface rs_station_if #(
    parameter int TAG_W  = tomasulo_pkg::TAG_W,
    parameter int DATA_W = tomasulo_pkg::DATA_W,
    parameter int OP_W   = tomasulo_pkg::OP_W
);
    logic              issue_valid;
    logic              issue_ready;
    logic [OP_W-1:0]   issue_op;
    logic [TAG_W-1:0]  issue_qj;
    logic [DATA_W-1:0] issue_vj;
    logic [TAG_W-1:0]  issue_qk;
    logic [DATA_W-1:0] issue_vk;
    logic [TAG_W-1:0]  issue_tag;
    logic              cdb_enable;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              ex_valid;
    logic              ex_ready;
    logic [OP_W-1:0]   ex_op;
    logic [DATA_W-1:0] ex_vj;
    logic [DATA_W-1:0] ex_vk;
    logic [TAG_W-1:0]  ex_tag;

    modport slave (
        input  issue_valid, issue_op, issue_qj, issue_vj, issue_qk, issue_vk,
        output issue_ready, issue_tag,
        input  cdb_enable, cdb_tag, cdb_data,
        output ex_valid, ex_op, ex_vj, ex_vk, ex_tag,
        input  ex_ready
    );

    modport master (
        output issue_valid, issue_op, issue_qj, issue_vj, issue_qk, issue_vk,
        input  issue_ready, issue_tag,
        output cdb_enable, cdb_tag, cdb_data,
        input  ex_valid, ex_op, ex_vj, ex_vk, ex_tag,
        output ex_ready
    );
endinterface

// File: rtl/rs_entry.sv
// One reservation-station slot: lifecycle state, opcode, operands and CDB snooping.
module rs_entry import tomasulo_pkg::*; #(
    parameter int TAG_W   = tomasulo_pkg::TAG_W,
    parameter int DATA_W  = tomasulo_pkg::DATA_W,
    parameter int OP_W    = tomasulo_pkg::OP_W,
    parameter int OWN_TAG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc,
    input  logic              dispatch,
    input  logic [OP_W-1:0]   issue_op,
    input  logic [TAG_W-1:0]  issue_qj,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic [TAG_W-1:0]  issue_qk,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic              cdb_enable,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output entry_state_t      state,
    output logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] vj,
    output logic [DATA_W-1:0] vk
);
    entry_state_t      state_q, state_d;
    logic [OP_W-1:0]   op_q;
    logic [TAG_W-1:0]  qj_q, qk_q, src_qj, src_qk, qj_d, qk_d;
    logic [DATA_W-1:0] vj_q, vk_q, src_vj, src_vk, vj_d, vk_d;
    logic              cdb_live, hit_j, hit_k, own_hit, load;

    // Operands come from the issue bus while FREE so the issue-cycle bypass shares the comparators.
    always_comb begin
        cdb_live = cdb_enable && (cdb_tag != TAG_W'(TAG_NONE));
        src_qj   = (state_q == FREE) ? issue_qj : qj_q;
        src_qk   = (state_q == FREE) ? issue_qk : qk_q;
        src_vj   = (state_q == FREE) ? issue_vj : vj_q;
        src_vk   = (state_q == FREE) ? issue_vk : vk_q;
        hit_j    = cdb_live && (src_qj == cdb_tag);
        hit_k    = cdb_live && (src_qk == cdb_tag);
        qj_d     = hit_j ? '0 : src_qj;
        qk_d     = hit_k ? '0 : src_qk;
        vj_d     = hit_j ? cdb_data : src_vj;
        vk_d     = hit_k ? cdb_data : src_vk;
        own_hit  = cdb_live && (cdb_tag == TAG_W'(OWN_TAG));
        load     = (state_q == FREE && alloc) || (state_q == WAIT);
    end

    // NOTE: state_d is assigned before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FREE:    if (alloc) state_d = (qj_d != '0 || qk_d != '0) ? WAIT : READY;
            WAIT:    if (qj_d == '0 && qk_d == '0) state_d = READY;
            READY:   if (dispatch) state_d = EXEC;
            EXEC:    if (own_hit) state_d = FREE;
            default: state_d = FREE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= FREE;
        else     state_q <= state_d;
    end

    // NOTE: payload registers are cleared on reset too, so ex_* never expose stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= '0;
            qj_q <= '0;
            qk_q <= '0;
            vj_q <= '0;
            vk_q <= '0;
        end else if (load) begin
            if (state_q == FREE) op_q <= issue_op;
            qj_q <= qj_d;
            qk_q <= qk_d;
            vj_q <= vj_d;
            vk_q <= vk_d;
        end
    end

    always_ff @(posedge clk) begin
        assert (rst || !own_hit || state_q == EXEC)
            else $warning("rs_entry tag %0d: CDB broadcast of own tag while not executing", OWN_TAG);
    end

    assign state = state_q;
    assign op    = op_q;
    assign vj    = vj_q;
    assign vk    = vk_q;
endmodule

// File: rtl/rs_station.sv
// Reservation station: allocates issued work, snoops the CDB and dispatches ready entries.
module rs_station import tomasulo_pkg::*; #(
    parameter int N_ENTRIES = 3,
    parameter int TAG_W     = tomasulo_pkg::TAG_W,
    parameter int DATA_W    = tomasulo_pkg::DATA_W,
    parameter int OP_W      = tomasulo_pkg::OP_W,
    parameter int BASE_TAG  = ADD_BASE_TAG
) (
    input logic         clk,
    input logic         rst,
    rs_station_if.slave bus
);
    localparam int IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

    if (BASE_TAG == 0 || N_ENTRIES < 1 || N_ENTRIES > 8 ||
        BASE_TAG + N_ENTRIES - 1 > (1 << TAG_W) - 1) begin : g_bad_params
        $error("rs_station: BASE_TAG/N_ENTRIES outside the tag space");
    end

    entry_state_t      state [N_ENTRIES];
    logic [OP_W-1:0]   op    [N_ENTRIES];
    logic [DATA_W-1:0] vj    [N_ENTRIES];
    logic [DATA_W-1:0] vk    [N_ENTRIES];
    logic [N_ENTRIES-1:0] alloc, dispatch;
    logic [IDX_W-1:0]  alloc_idx, sel_idx;
    logic              any_free, any_ready, issue_fire, ex_fire;

    // Descending scan leaves the lowest matching index in place.
    always_comb begin
        any_free  = 1'b0;
        any_ready = 1'b0;
        alloc_idx = '0;
        sel_idx   = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (state[i] == FREE)  begin any_free  = 1'b1; alloc_idx = IDX_W'(i); end
            if (state[i] == READY) begin any_ready = 1'b1; sel_idx   = IDX_W'(i); end
        end
    end

    assign issue_fire = bus.issue_valid && any_free && !rst;
    assign ex_fire    = bus.ex_ready && any_ready && !rst;

    always_comb begin
        for (int i = 0; i < N_ENTRIES; i++) begin
            alloc[i]    = issue_fire && (alloc_idx == IDX_W'(i));
            dispatch[i] = ex_fire && (sel_idx == IDX_W'(i));
        end
    end

    for (genvar i = 0; i < N_ENTRIES; i++) begin : g_entry
        rs_entry #(
            .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W), .OWN_TAG(BASE_TAG + i)
        ) u_entry (
            .clk(clk), .rst(rst), .alloc(alloc[i]), .dispatch(dispatch[i]),
            .issue_op(bus.issue_op), .issue_qj(bus.issue_qj), .issue_vj(bus.issue_vj),
            .issue_qk(bus.issue_qk), .issue_vk(bus.issue_vk),
            .cdb_enable(bus.cdb_enable), .cdb_tag(bus.cdb_tag), .cdb_data(bus.cdb_data),
            .state(state[i]), .op(op[i]), .vj(vj[i]), .vk(vk[i])
        );
    end

    assign bus.issue_ready = any_free && !rst;
    assign bus.issue_tag   = (any_free && !rst) ? TAG_W'(BASE_TAG) + TAG_W'(alloc_idx) : '0;
    assign bus.ex_valid    = any_ready && !rst;

    always_comb begin
        bus.ex_op  = '0;
        bus.ex_vj  = '0;
        bus.ex_vk  = '0;
        bus.ex_tag = '0;
        if (any_ready && !rst) begin
            bus.ex_op  = op[sel_idx];
            bus.ex_vj  = vj[sel_idx];
            bus.ex_vk  = vk[sel_idx];
            bus.ex_tag = TAG_W'(BASE_TAG) + TAG_W'(sel_idx);
        end
    end
endmodule

// File: tb/tb_rs_station.sv
// Directed bench for the ADD-class reservation station (tags 1..3).
module tb_rs_station;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    rs_station_if #(.TAG_W(5), .DATA_W(32), .OP_W(4)) bus ();

    rs_station #(
        .N_ENTRIES(3), .TAG_W(5), .DATA_W(32), .OP_W(4), .BASE_TAG(1)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_set(input logic [3:0] op, input logic [4:0] qj, input logic [31:0] vj,
                             input logic [4:0] qk, input logic [31:0] vk);
        bus.issue_valid = 1'b1;
        bus.issue_op    = op;
        bus.issue_qj    = qj;
        bus.issue_vj    = vj;
        bus.issue_qk    = qk;
        bus.issue_vk    = vk;
    endtask

    task automatic cdb(input logic [4:0] tag, input logic [31:0] data);
        bus.cdb_enable = 1'b1;
        bus.cdb_tag    = tag;
        bus.cdb_data   = data;
    endtask

    task automatic cdb_off();
        bus.cdb_enable = 1'b0;
        bus.cdb_tag    = '0;
        bus.cdb_data   = '0;
    endtask

    initial begin
        rst = 1'b1;
        issue_set(0, 0, 0, 0, 0);
        bus.issue_valid = 1'b0;
        bus.ex_ready    = 1'b0;
        cdb_off();
        step();
        step();
        check("rst_issue_ready", 32'(bus.issue_ready), 0);
        check("rst_ex_valid", 32'(bus.ex_valid), 0);
        check("rst_ex_tag", 32'(bus.ex_tag), 0);
        check("rst_ex_vj", bus.ex_vj, 0);
        rst = 1'b0;
        #1;
        check("idle_issue_ready", 32'(bus.issue_ready), 1);

        // Both operands valid: ready one cycle after issue, freed by own tag.
        issue_set(2, 0, 5, 0, 7);
        #1;
        check("t1_issue_tag", 32'(bus.issue_tag), 1);
        step();
        bus.issue_valid = 1'b0;
        #1;
        check("t1_ex_valid", 32'(bus.ex_valid), 1);
        check("t1_ex_op", 32'(bus.ex_op), 2);
        check("t1_ex_vj", bus.ex_vj, 5);
        check("t1_ex_vk", bus.ex_vk, 7);
        check("t1_ex_tag", 32'(bus.ex_tag), 1);
        bus.ex_ready = 1'b1;
        step();
        bus.ex_ready = 1'b0;
        #1;
        check("t1_exec_ex_valid", 32'(bus.ex_valid), 0);
        check("t1_exec_issue_tag", 32'(bus.issue_tag), 2);
        cdb(1, 32'h1234);
        step();
        cdb_off();
        #1;
        check("t1_freed_issue_ready", 32'(bus.issue_ready), 1);
        check("t1_freed_issue_tag", 32'(bus.issue_tag), 1);

        // Operand j waits on tag 9; tag-0 broadcast is ignored.
        issue_set(1, 9, 0, 0, 3);
        step();
        bus.issue_valid = 1'b0;
        #1;
        check("t2_wait_ex_valid", 32'(bus.ex_valid), 0);
        cdb(0, 32'hEE);
        step();
        #1;
        check("t2_tag0_ex_valid", 32'(bus.ex_valid), 0);
        cdb(9, 32'h55);
        step();
        cdb_off();
        #1;
        check("t2_ex_valid", 32'(bus.ex_valid), 1);
        check("t2_ex_vj", bus.ex_vj, 32'h55);
        check("t2_ex_vk", bus.ex_vk, 3);
        bus.ex_ready = 1'b1;
        step();
        bus.ex_ready = 1'b0;
        cdb(1, 0);
        step();
        cdb_off();

        // Issue-cycle bypass of both operands.
        issue_set(4, 9, 0, 9, 0);
        cdb(9, 32'hAA);
        step();
        bus.issue_valid = 1'b0;
        cdb_off();
        #1;
        check("t3_ex_valid", 32'(bus.ex_valid), 1);
        check("t3_ex_vj", bus.ex_vj, 32'hAA);
        check("t3_ex_vk", bus.ex_vk, 32'hAA);
        bus.ex_ready = 1'b1;
        step();
        bus.ex_ready = 1'b0;
        cdb(1, 0);
        step();
        cdb_off();

        // Fill all three entries, dispatch them, free entry 2 and re-allocate it.
        issue_set(3, 0, 1, 0, 1);
        step();
        step();
        step();
        #1;
        check("t4_full_issue_ready", 32'(bus.issue_ready), 0);
        check("t4_full_ex_tag", 32'(bus.ex_tag), 1);
        issue_set(7, 0, 32'h70, 0, 32'h07);
        bus.ex_ready = 1'b1;
        step();
        check("t4_disp_tag2", 32'(bus.ex_tag), 2);
        step();
        check("t4_disp_tag3", 32'(bus.ex_tag), 3);
        step();
        bus.ex_ready = 1'b0;
        #1;
        check("t4_all_exec_ex_valid", 32'(bus.ex_valid), 0);
        check("t4_still_full", 32'(bus.issue_ready), 0);
        cdb(3, 0);
        step();
        cdb_off();
        #1;
        check("t4_freed_ready", 32'(bus.issue_ready), 1);
        check("t4_freed_tag", 32'(bus.issue_tag), 3);
        step();
        bus.issue_valid = 1'b0;
        #1;
        check("t4_refull", 32'(bus.issue_ready), 0);
        check("t4_new_ex_tag", 32'(bus.ex_tag), 3);
        check("t4_new_ex_op", 32'(bus.ex_op), 7);
        check("t4_new_ex_vj", bus.ex_vj, 32'h70);
        bus.ex_ready = 1'b1;
        step();
        bus.ex_ready = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            cdb(5'(t), 0);
            step();
        end
        cdb_off();

        // Entries 0 and 2 ready together, entry 1 still waiting.
        issue_set(1, 8, 0, 0, 1);
        step();
        issue_set(1, 9, 0, 0, 2);
        step();
        issue_set(5, 0, 32'h33, 0, 32'h44);
        step();
        bus.issue_valid = 1'b0;
        #1;
        check("t5_only_e2_tag", 32'(bus.ex_tag), 3);
        cdb(8, 32'h88);
        step();
        cdb_off();
        #1;
        check("t5_prio_tag", 32'(bus.ex_tag), 1);
        step();
        check("t5_hold_tag", 32'(bus.ex_tag), 1);
        check("t5_hold_valid", 32'(bus.ex_valid), 1);
        check("t5_hold_vj", bus.ex_vj, 32'h88);
        bus.ex_ready = 1'b1;
        step();
        check("t5_second_tag", 32'(bus.ex_tag), 3);
        check("t5_second_vk", bus.ex_vk, 32'h44);
        step();
        bus.ex_ready = 1'b0;
        #1;
        check("t5_none_ready", 32'(bus.ex_valid), 0);

        // Reset with entries in WAIT and EXEC drops them all.
        rst = 1'b1;
        cdb(9, 32'h99);
        step();
        check("t6_rst_issue_ready", 32'(bus.issue_ready), 0);
        check("t6_rst_ex_valid", 32'(bus.ex_valid), 0);
        rst = 1'b0;
        cdb_off();
        #1;
        check("t6_issue_ready", 32'(bus.issue_ready), 1);
        check("t6_issue_tag", 32'(bus.issue_tag), 1);
        cdb(9, 32'h99);
        step();
        cdb_off();
        #1;
        check("t6_late_cdb_ex_valid", 32'(bus.ex_valid), 0);
        check("t6_late_cdb_issue_tag", 32'(bus.issue_tag), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
